// File: rtl/mc_jtag_debug_dispatch_if.sv
// Request/acknowledge bus between the debug dispatcher and the per-core
// debug modules. The dispatcher drives one request level per core together
// with the IR and scan word of the command in service. Each core answers
// with a single-cycle acknowledge.
interface mc_jtag_debug_dispatch_if #(
  parameter int N_CORES = 4,
  parameter int SR_W    = 38,
  parameter int IR_W    = 2
);
  logic [N_CORES-1:0] core_req;
  logic [N_CORES-1:0] core_ack;
  logic [IR_W-1:0]    core_ir;
  logic [SR_W-1:0]    core_data;

  modport master (
    output core_req,
    output core_ir,
    output core_data,
    input  core_ack
  );

  modport slave (
    input  core_req,
    input  core_ir,
    input  core_data,
    output core_ack
  );
endinterface

// File: rtl/mc_jtag_debug_dispatch.sv
// System-clock-side JTAG debug command dispatcher.
// - Synchronises the TCK-domain update strobes.
// - Queues every updated scan word, together with its IR, in a small FIFO.
// - Hands each command to one core, or to all cores, over a req/ack bus.
// - Reports timeouts, overflows and bad core selects as sticky errors.
module mc_jtag_debug_dispatch #(
  parameter int N_CORES     = 4,
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int CSEL_W      = 3,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic [IR_W-1:0]            ir_in,
  input  logic [SR_W-1:0]            sr,
  input  logic                       clr_status,
  mc_jtag_debug_dispatch_if.master   core_bus,
  output logic [SR_W-1:0]            jdo,
  output logic                       ir_update,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       err_timeout,
  output logic                       err_overflow,
  output logic                       err_badsel,
  output logic [7:0]                 drop_count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = IR_W + SR_W;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT
  } state_t;

  // ---------------------------------------------------------------------
  // Strobe synchronisers and rising-edge detectors
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic                   udr_prev_q, udr_prev_d;
  logic                   uir_prev_q, uir_prev_d;
  logic                   ir_update_q, ir_update_d;
  logic [SR_W-1:0]        jdo_q, jdo_d;
  logic                   udr_edge;
  logic                   uir_edge;

  // FIFO state
  logic [ENTRY_W-1:0]     fifo_mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       count_q, count_d;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   overflow;
  logic [ENTRY_W-1:0]     head_entry;

  // Dispatch FSM state
  state_t                 state_q, state_d;
  logic [N_CORES-1:0]     pending_q, pending_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [TMR_W-1:0]       timer_inc;
  logic [IR_W-1:0]        core_ir_q, core_ir_d;
  logic [SR_W-1:0]        core_data_q, core_data_d;
  logic [CSEL_W-1:0]      sel;
  logic [N_CORES-1:0]     sel_onehot;
  logic                   sel_bcast;
  logic                   sel_valid;
  logic                   badsel_set;
  logic                   timeout_set;

  // Status
  logic                   busy_q, busy_d;
  logic                   err_timeout_q, err_timeout_d;
  logic                   err_overflow_q, err_overflow_d;
  logic                   err_badsel_q, err_badsel_d;
  logic [7:0]             drop_count_q, drop_count_d;
  logic [1:0]             drop_inc;
  logic [7:0]             drop_base;
  logic [8:0]             drop_sum;

  // Shift the raw strobes through the synchronisers and flag rising edges
  always_comb begin
    udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_prev_d  = udr_sync_q[SYNC_STAGES-1];
    uir_prev_d  = uir_sync_q[SYNC_STAGES-1];
    udr_edge    = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
    uir_edge    = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
    ir_update_d = uir_edge;
    jdo_d       = udr_edge ? sr : jdo_q;
  end

  // ---------------------------------------------------------------------
  // Command FIFO. A full FIFO still accepts a push when the head is popped
  // in the same cycle; otherwise the new command is dropped and counted.
  // ---------------------------------------------------------------------
  // FIFO push/pop decisions and pointer/occupancy update
  always_comb begin
    fifo_full  = (count_q == LVL_W'(DEPTH));
    fifo_empty = (count_q == '0);
    head_entry = fifo_mem_q[rd_ptr_q];
    pop        = (state_q == ST_IDLE) && !fifo_empty;
    push       = udr_edge && (!fifo_full || pop);
    overflow   = udr_edge && fifo_full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; no reset so it maps onto plain RAM
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {ir_in, sr};
    end
  end

  // ---------------------------------------------------------------------
  // Core-select decode of the command in service
  // ---------------------------------------------------------------------
  assign sel       = core_data_q[SR_W-1 -: CSEL_W];
  assign sel_bcast = &sel;
  assign sel_valid = (sel < CSEL_W'(N_CORES));

  genvar gi;
  generate
    for (gi = 0; gi < N_CORES; gi++) begin : g_sel_dec
      assign sel_onehot[gi] = (sel == CSEL_W'(gi));
    end
  endgenerate

  // Dispatch FSM: pop, decode, then wait for every addressed core to ack
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    timer_d     = timer_q;
    core_ir_d   = core_ir_q;
    core_data_d = core_data_q;
    badsel_set  = 1'b0;
    timeout_set = 1'b0;
    timer_inc   = timer_q + TMR_W'(1);
    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          {core_ir_d, core_data_d} = head_entry;
          state_d                  = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        timer_d = '0;
        if (sel_bcast) begin
          pending_d = '1;
          state_d   = ST_WAIT;
        end else if (sel_valid) begin
          pending_d = sel_onehot;
          state_d   = ST_WAIT;
        end else begin
          pending_d  = '0;
          badsel_set = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Acks for cores not pending are masked off by the AND.
        pending_d = pending_q & ~core_bus.core_ack;
        if (pending_d == '0) begin
          // The last ack beats a simultaneous timeout.
          state_d = ST_IDLE;
        end else if (timer_inc == TMR_W'(TIMEOUT)) begin
          timeout_set = 1'b1;
          pending_d   = '0;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: begin
        pending_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // Sticky errors, saturating drop counter and registered busy flag
  always_comb begin
    err_timeout_d  = (err_timeout_q  & ~clr_status) | timeout_set;
    err_overflow_d = (err_overflow_q & ~clr_status) | overflow;
    err_badsel_d   = (err_badsel_q   & ~clr_status) | badsel_set;
    drop_inc       = {1'b0, overflow} + {1'b0, badsel_set};
    drop_base      = clr_status ? 8'd0 : drop_count_q;
    drop_sum       = {1'b0, drop_base} + {7'd0, drop_inc};
    drop_count_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    busy_d         = (state_d != ST_IDLE) || (count_d != '0);
  end

  // All control and status registers, cleared by the asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q     <= '0;
      uir_sync_q     <= '0;
      udr_prev_q     <= 1'b0;
      uir_prev_q     <= 1'b0;
      ir_update_q    <= 1'b0;
      jdo_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      timer_q        <= '0;
      core_ir_q      <= '0;
      core_data_q    <= '0;
      busy_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
      err_badsel_q   <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      udr_sync_q     <= udr_sync_d;
      uir_sync_q     <= uir_sync_d;
      udr_prev_q     <= udr_prev_d;
      uir_prev_q     <= uir_prev_d;
      ir_update_q    <= ir_update_d;
      jdo_q          <= jdo_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      pending_q      <= pending_d;
      timer_q        <= timer_d;
      core_ir_q      <= core_ir_d;
      core_data_q    <= core_data_d;
      busy_q         <= busy_d;
      err_timeout_q  <= err_timeout_d;
      err_overflow_q <= err_overflow_d;
      err_badsel_q   <= err_badsel_d;
      drop_count_q   <= drop_count_d;
    end
  end

  // The pending mask doubles as the request level, so requests drop on
  // the same edge that retires the matching ack or the timeout.
  assign core_bus.core_req  = pending_q;
  assign core_bus.core_ir   = core_ir_q;
  assign core_bus.core_data = core_data_q;

  assign jdo          = jdo_q;
  assign ir_update    = ir_update_q;
  assign busy         = busy_q;
  assign fifo_level   = count_q;
  assign err_timeout  = err_timeout_q;
  assign err_overflow = err_overflow_q;
  assign err_badsel   = err_badsel_q;
  assign drop_count   = drop_count_q;

endmodule

// File: doc/mc_jtag_debug_dispatch.md
Name: mc_jtag_debug_dispatch

Overview:
System-clock-side JTAG debug command dispatcher for multicore Nios II systems.
- Synchronises the virtual-JTAG update strobes and captures each updated scan word with its IR into a command FIFO.
- Routes each command to one target core, or broadcasts it to all cores, over a req/ack handshake.
- Replaces the per-core single-cycle action decode with a shared, buffered, error-reporting front end, sitting between the JTAG TCK-domain shift logic and N CPU debug modules.

Parameters:
N_CORES, 4, number of target cores (1..7)
SR_W, 38, scan-register / jdo width
IR_W, 2, virtual IR width
CSEL_W, 3, core-select field width, sr[SR_W-1 -: CSEL_W]; all-ones = broadcast
DEPTH, 4, command FIFO depth (power of 2, >=2)
TIMEOUT, 255, max clk cycles waiting for acks (>=1)
SYNC_STAGES, 2, synchroniser flops for vs_udr/vs_uir (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
vs_udr  in  1  update-DR strobe, TCK domain, async to clk
vs_uir  in  1  update-IR strobe, TCK domain, async to clk
ir_in  in  IR_W  virtual IR, quasi-static around strobes
sr  in  SR_W  scan register, stable while vs_udr high
core_ack  in  N_CORES  per-core single-cycle acknowledge
clr_status  in  1  clears sticky errors and drop counter
jdo  out  SR_W  last captured sr
ir_update  out  1  one-cycle pulse per vs_uir rising edge
core_req  out  N_CORES  per-core request level
core_ir  out  IR_W  IR of command in service
core_data  out  SR_W  sr of command in service
busy  out  1  FSM not IDLE or FIFO non-empty
fifo_level  out  clog2(DEPTH)+1  FIFO occupancy
err_timeout  out  1  sticky
err_overflow  out  1  sticky
err_badsel  out  1  sticky
drop_count  out  8  dropped commands, saturates at 255

Behaviour:
- Reset (async, active-low): every output, FIFO pointers, synchronisers, counters and FSM go to 0/IDLE. core_req drops immediately; no partial command survives.
- vs_udr and vs_uir each pass through SYNC_STAGES flops, then a rising-edge detector (the previous synced value is also reset to 0).
- udr edge cycle:
  - jdo <= sr.
  - If FIFO not full, push {ir_in, sr}.
  - If FIFO full, do not push; set err_overflow; drop_count += 1.
  - A push and a pop in the same cycle at full are both accepted.
- uir edge: ir_update = 1 for exactly one cycle. No FIFO effect.
- FSM:
  - IDLE: FIFO non-empty -> pop head into core_ir/core_data, go to DISPATCH.
  - DISPATCH: decode sel = core_data[SR_W-1 -: CSEL_W].
    - sel < N_CORES: pending = one-hot(sel).
    - sel all-ones: pending = all N_CORES bits set.
    - Otherwise: set err_badsel, drop_count += 1, return to IDLE with no req.
    - Load timer = 0, go to WAIT.
  - WAIT: core_req = pending (registered). A core_ack[i] seen while pending[i] = 1 clears pending[i] and core_req[i] on the next edge. An ack with pending[i] = 0 is ignored.
    - pending == 0 -> IDLE.
    - Otherwise timer += 1. When timer == TIMEOUT with acks still outstanding: set err_timeout, clear pending/core_req, go to IDLE.
    - If the last ack arrives in the same cycle as the timeout, the ack wins (no error).
- Latency: FIFO empty and FSM idle -> core_req rises SYNC_STAGES+3 clk edges after the first edge that samples vs_udr high. core_ir/core_data remain stable while any core_req bit is set.
- Back-to-back commands: at least one IDLE cycle between successive WAIT phases.
- Status:
  - Sticky errors are cleared by clr_status, which also zeroes drop_count.
  - An error set in the same cycle as clr_status stays set; a drop in that cycle leaves drop_count = 1.
- fifo_level and busy are registered and updated on the same edge as the push/pop.

Test Plan:
- Reset then a single udr pulse with sr sel = 2, ir_in = 2'b01 -> core_req = 4'b0100 exactly 5 edges after first high sample; core_ir = 01; core_data = sr. Ack at cycle 8 -> core_req = 0 at cycle 9; busy = 0.
- Broadcast: sel = 3'b111, cores ack on cycles 2, 5, 5, 9 of WAIT -> core_req bits clear individually; IDLE after the last ack; err_timeout = 0.
- Overflow: 6 udr pulses with no acks, DEPTH = 4 -> one command in service, 4 queued, 1 dropped; err_overflow = 1; drop_count = 1; fifo_level = 4.
- Timeout: sel = 1, never ack, TIMEOUT = 255 -> err_timeout = 1 and core_req = 0 after 255 WAIT cycles. Next command dispatches normally. clr_status -> all errors 0, drop_count = 0.
- Bad select: sel = 5 with N_CORES = 4 -> no core_req; err_badsel = 1; drop_count increments. uir pulse -> ir_update high for exactly one cycle.
- Reset asserted mid-WAIT with 2 commands queued -> core_req = 0 asynchronously. After release: fifo_level = 0, busy = 0, all errors 0.
